// File: rtl/flag_register_pkg.sv
// Shared encodings for the FLAG bus producer: op classes, flag bit positions,
// controller states and the per-class update mask.
package flag_register_pkg;

    localparam int DEF_WIDTH = 16;

    // Bit positions must line up with the PC-control FLAG decode.
    localparam int FLG_N = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_V = 2;

    typedef enum logic [1:0] {
        OPC_NONE  = 2'b00,
        OPC_ARITH = 2'b01,
        OPC_LOGIC = 2'b10,
        OPC_CMP   = 2'b11
    } opc_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    function automatic logic [2:0] opc_mask(input logic [1:0] op_class);
        logic [2:0] m;
        m = 3'b000;
        case (op_class)
            OPC_NONE:  m = 3'b000;
            OPC_ARITH: m = 3'b111;
            OPC_LOGIC: m = 3'b010;
            OPC_CMP:   m = 3'b111;
            default:   m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_register_if.sv
// Commit-side bus between the ALU/commit stage and the flag register,
// including the FLAG outputs read by PC control.
interface flag_register_if
    import flag_register_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             en;
    logic [1:0]       op_class;
    logic [WIDTH-1:0] result;
    logic             ovfl;
    logic             hlt;
    logic [2:0]       flag;
    logic [2:0]       flag_next;
    logic             flag_valid;
    logic             halted;

    modport master (
        output en, op_class, result, ovfl, hlt,
        input  flag, flag_next, flag_valid, halted
    );

    modport slave (
        input  en, op_class, result, ovfl, hlt,
        output flag, flag_next, flag_valid, halted
    );

endinterface

// File: rtl/flag_register_calc.sv
// Combinational raw-flag derivation and per-class update mask.
module flag_calc
    import flag_register_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] result,
    input  logic             ovfl,
    input  logic [1:0]       op_class,
    output logic [2:0]       raw,
    output logic [2:0]       mask
);

    always_comb begin
        raw        = 3'b000;
        raw[FLG_N] = result[WIDTH-1];
        raw[FLG_Z] = (result == {WIDTH{1'b0}});
        raw[FLG_V] = ovfl;
        mask       = opc_mask(op_class);
    end

endmodule

// File: rtl/flag_register.sv
// Registered N/Z/V flags with per-class masking and an absorbing halt state.
//   state   | meaning
//   ST_RUN  | committing instructions update flags; hlt moves to ST_HALT
//   ST_HALT | flags frozen, all inputs ignored until rst
module flag_register
    import flag_register_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    flag_register_if.slave bus
);

    state_e     state_q, state_d;
    logic [2:0] flag_q, flag_d;
    logic       valid_q, valid_d;
    logic       commit;
    logic [2:0] raw;
    logic [2:0] mask;

    flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
        .result   (bus.result),
        .ovfl     (bus.ovfl),
        .op_class (bus.op_class),
        .raw      (raw),
        .mask     (mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            flag_q  <= 3'b000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        valid_d = valid_q;
        commit  = 1'b0;
        case (state_q)
            ST_RUN: begin
                commit = bus.en;
                if (commit) begin
                    flag_d = (flag_q & ~mask) | (raw & mask);
                    if (mask != 3'b000) valid_d = 1'b1;
                    if (bus.hlt) state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    assign bus.flag       = flag_q;
    assign bus.flag_next  = flag_d;
    assign bus.flag_valid = valid_q;
    assign bus.halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_flag_register.sv
// Directed bench for flag_register: driver queues hand-computed expectations,
// a monitor checks flag_next before each edge and registered outputs after it.
module tb_flag_register;

    typedef struct {
        logic [2:0] nx;
        logic [2:0] fl;
        logic       vl;
        logic       hl;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    flag_register_if #(.WIDTH(16)) bus ();

    flag_register #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic en, input logic [1:0] opc, input logic [15:0] res,
                        input logic ov, input logic hlt, input logic [2:0] nx,
                        input logic [2:0] fl, input logic vl, input logic hl);
        exp_t e;
        @(negedge clk);
        bus.en       = en;
        bus.op_class = opc;
        bus.result   = res;
        bus.ovfl     = ov;
        bus.hlt      = hlt;
        e.nx = nx; e.fl = fl; e.vl = vl; e.hl = hl;
        sb.push_back(e);
    endtask

    // Asserts rst between edges and checks that it takes effect without a clock.
    task automatic async_reset(input string nm);
        @(posedge clk);
        #2;
        bus.en  = 1'b0;
        bus.hlt = 1'b0;
        rst     = 1'b1;
        #1;
        check({nm, "_flag"},   16'(bus.flag),       16'h0);
        check({nm, "_valid"},  16'(bus.flag_valid), 16'h0);
        check({nm, "_halted"}, 16'(bus.halted),     16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("flag_next", 16'(bus.flag_next), 16'(e.nx));
                @(posedge clk);
                #1;
                check("flag",       16'(bus.flag),       16'(e.fl));
                check("flag_valid", 16'(bus.flag_valid), 16'(e.vl));
                check("halted",     16'(bus.halted),     16'(e.hl));
            end
        end
    end

    initial begin : driver
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.op_class = 2'b00;
        bus.result   = 16'h0;
        bus.ovfl     = 1'b0;
        bus.hlt      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_flag",   16'(bus.flag),       16'h0);
        check("rst_valid",  16'(bus.flag_valid), 16'h0);
        check("rst_halted", 16'(bus.halted),     16'h0);
        rst = 1'b0;

        //   en  opc    result    ov  hlt  next    flag    vl  hl
        step(1, 2'b00, 16'h0000, 0, 0, 3'b000, 3'b000, 0, 0);
        step(1, 2'b01, 16'h8000, 1, 0, 3'b101, 3'b101, 1, 0);
        step(1, 2'b10, 16'h0000, 1, 0, 3'b111, 3'b111, 1, 0);
        step(0, 2'b01, 16'h0000, 0, 0, 3'b111, 3'b111, 1, 0);
        step(0, 2'b01, 16'h0000, 0, 0, 3'b111, 3'b111, 1, 0);
        step(0, 2'b01, 16'h0000, 0, 0, 3'b111, 3'b111, 1, 0);
        step(1, 2'b01, 16'h0001, 0, 0, 3'b000, 3'b000, 1, 0);
        step(0, 2'b11, 16'h8000, 1, 1, 3'b000, 3'b000, 1, 0);
        step(1, 2'b11, 16'h8000, 1, 0, 3'b101, 3'b101, 1, 0);
        step(1, 2'b10, 16'h8000, 0, 0, 3'b101, 3'b101, 1, 0);
        step(1, 2'b11, 16'hFFFF, 0, 0, 3'b001, 3'b001, 1, 0);
        step(1, 2'b11, 16'h0000, 0, 1, 3'b010, 3'b010, 1, 1);
        step(1, 2'b01, 16'h8000, 1, 0, 3'b010, 3'b010, 1, 1);
        step(1, 2'b01, 16'h0000, 0, 1, 3'b010, 3'b010, 1, 1);
        async_reset("rst_halt");

        step(1, 2'b00, 16'h0000, 0, 0, 3'b000, 3'b000, 0, 0);
        step(1, 2'b01, 16'h8000, 1, 0, 3'b101, 3'b101, 1, 0);
        step(1, 2'b10, 16'h0000, 0, 0, 3'b111, 3'b111, 1, 0);
        async_reset("rst_run");

        step(1, 2'b01, 16'h0000, 0, 0, 3'b010, 3'b010, 1, 0);
        step(1, 2'b10, 16'h0001, 0, 1, 3'b000, 3'b000, 1, 1);

        repeat (4) @(posedge clk);
        #3;
        check("sb_drained", 16'(sb.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
